round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
//  Game-round controller for Game of Codes. Sequences each question round:
//   - requests a question from the question generator;
//   - times the answer slot;
//   - accepts only the first keypad press per round;
//   - applies the score update and shows feedback;
//   - ends the game on max score or max rounds.
//  Owns the score register that feeds the 7-segment display. Sits between the
//  keypad module (key_valid) and the answer checker (answer), and the display.
// PARAMETERS
//  SLOT_CYCLES  800_000_000  answer-slot length in clk_fast cycles (8 s @ 100 MHz)
//  SHOW_CYCLES  100_000_000  feedback display length in cycles (1 s)
//  MAX_SCORE    9            score saturation value; reaching it ends the game
//  MAX_ROUNDS   15           rounds per game
//  TMR_W        30           timer width; must hold max(SLOT_CYCLES,SHOW_CYCLES)
// PORTS
//  clk_fast    in   1  100 MHz system clock
//  restart_n   in   1  async active-low reset
//  start       in   1  level; in IDLE/OVER begins a new game
//  key_valid   in   1  1-cycle pulse from keypad: a key was pressed
//  answer      in   1  validity of pressed key; sampled with key_valid
//  q_ack       in   1  question generator: new question loaded
//  q_req       out  1  request next question; held until q_ack
//  score       out  4  current points, to 7-seg digit 0
//  round       out  4  rounds completed this game
//  feedback    out  2  00 none, 01 correct, 10 wrong, 11 timeout
//  game_over   out  1  high in OVER state
// BEHAVIOUR
//  Reset (async, restart_n=0)
//   - state=IDLE; score=0, round=0, q_req=0, feedback=00, game_over=0; timer=0.
//   - Reset mid-round abandons the round; no score change is kept.
//  States: IDLE, REQ, ASK, SHOW, OVER
//   IDLE
//    - start=1 -> REQ; score and round cleared on that edge.
//   REQ
//    - q_req=1.
//    - q_ack=1 -> ASK; q_req low next cycle; timer loaded SLOT_CYCLES-1.
//    - feedback cleared to 00.
//   ASK
//    - timer decrements each cycle.
//    - First key_valid: answer=1 -> score+1, saturating at MAX_SCORE, fb=01;
//      answer=0 -> score-1, floored at 0, fb=10; -> SHOW; timer=SHOW_CYCLES-1.
//    - Score visible the cycle after the key_valid edge (1-cycle latency).
//    - timer==0 with no key: fb=11, timeout handling per CONFIGURATION; -> SHOW.
//    - key_valid on the same cycle as timer==0: the key wins (no timeout).
//   SHOW
//    - key_valid ignored (second-press lockout); timer counts down.
//    - At timer==0: round+1. Then, if score==MAX_SCORE or round+1==MAX_ROUNDS
//      -> OVER; else -> REQ.
//   OVER
//    - game_over=1; key_valid and q_ack ignored; score and round frozen.
//    - start=1 -> REQ; score and round cleared; game_over drops.
//  Other rules
//   - q_ack outside REQ is ignored. start outside IDLE/OVER is ignored.
//   - round does not wrap: max value is MAX_ROUNDS.
//   - All outputs are registered.
// CONFIGURATION
//  TIMEOUT_PENALTY_EN defined
//   - Timeout in ASK decrements score (floored at 0), as a wrong answer does.
//  TIMEOUT_PENALTY_EN undefined
//   - Timeout leaves score unchanged; fb=11 and the round still advances.
// STRUCTURE
//  game_pkg
//   - typedef enum logic [2:0] round_state_t {IDLE,REQ,ASK,SHOW,OVER}
//   - typedef enum logic [1:0] feedback_t {FB_NONE,FB_OK,FB_BAD,FB_TMO}
//   - localparam SCORE_W=4
//  Sub-module slot_timer
//   - Loadable down-counter, TMR_W bits; ports load, load_val, en, zero.
//   - Shared by the ASK and SHOW phases. FSM and score logic stay in the top.
// TESTING  (SLOT_CYCLES=20, SHOW_CYCLES=4 for sim)
//  1. Reset, start, q_ack; key_valid with answer=1 at cycle 5 of ASK
//     -> score 0->1 next cycle, fb=01, SHOW 4 cycles, round=1, q_req reasserts.
//  2. score=0, answer=0 key -> score stays 0, fb=10.
//     score=3, answer=0 -> score 2.
//  3. No key for 20 cycles, score=2 -> fb=11; score 1 with TIMEOUT_PENALTY_EN,
//     score 2 without.
//  4. Two key_valid pulses in ASK, then one in SHOW -> only the first counts
//     (score changes by exactly 1).
//  5. Nine correct answers -> score=9, game_over=1; further keys leave score 9;
//     start -> score 0, round 0, q_req=1.
//  6. restart_n low mid-ASK, asynchronously -> all outputs at reset values
//     immediately; key_valid at timer==0 -> fb=01, not 11.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and helpers for the Game of Codes round controller.
// Holds the FSM state and feedback encodings and the saturating score step.
package game_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {IDLE, REQ, ASK, SHOW, OVER} round_state_t;
  typedef enum logic [1:0] {FB_NONE, FB_OK, FB_BAD, FB_TMO} feedback_t;

  // One point up (capped at max_s) or one point down (floored at zero)
  function automatic logic [SCORE_W-1:0] score_step(
    input logic [SCORE_W-1:0] s,
    input logic               up,
    input logic [SCORE_W-1:0] max_s
  );
    if (up) begin
      return (s >= max_s) ? max_s : s + 1'b1;
    end
    return (s == '0) ? '0 : s - 1'b1;
  endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Handshake and display bundle between the round controller and its neighbours.
// slave = the round controller itself; master = keypad/checker/question side.
interface round_sequencer_if;
  import game_pkg::*;

  logic               start;
  logic               key_valid;
  logic               answer;
  logic               q_ack;
  logic               q_req;
  logic [SCORE_W-1:0] score;
  logic [3:0]         round;
  feedback_t          feedback;
  logic               game_over;

  modport slave (
    input  start, key_valid, answer, q_ack,
    output q_req, score, round, feedback, game_over
  );

  modport master (
    output start, key_valid, answer, q_ack,
    input  q_req, score, round, feedback, game_over
  );
endinterface

// File: rtl/round_sequencer_slot_timer.sv
// Loadable down-counter shared by the answer slot and the feedback display.
// Holds at zero once expired; load has priority over counting.
module slot_timer #(
  parameter int TMR_W = 30
) (
  input  logic             clk_fast,
  input  logic             restart_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [TMR_W-1:0] count_reg;

  always_ff @(posedge clk_fast or negedge restart_n) begin
    if (!restart_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: question request, timed answer slot, scoring, feedback.
// Build option: define TIMEOUT_PENALTY_EN to make a timeout cost one point.
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = 800_000_000,
  parameter int unsigned SHOW_CYCLES = 100_000_000,
  parameter int unsigned MAX_SCORE   = 9,
  parameter int unsigned MAX_ROUNDS  = 15,
  parameter int          TMR_W       = 30
) (
  input  logic              clk_fast,
  input  logic              restart_n,
  round_sequencer_if.slave  bus
);

  localparam logic [TMR_W-1:0]   SLOT_LOAD  = TMR_W'(SLOT_CYCLES - 1);
  localparam logic [TMR_W-1:0]   SHOW_LOAD  = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_TOP  = SCORE_W'(MAX_SCORE);
  localparam logic [3:0]         ROUND_LAST = 4'(MAX_ROUNDS);

  round_state_t       state_reg;
  logic [SCORE_W-1:0] score_reg;
  logic [3:0]         round_reg;
  feedback_t          feedback_reg;
  logic               q_req_reg;
  logic               game_over_reg;

  logic             timer_load;
  logic [TMR_W-1:0] timer_val;
  logic             timer_en;
  logic             timer_zero;
  logic [3:0]       round_next;

  // One timer serves both phases: the slot on question ack, the display on answer/timeout
  always_comb begin
    timer_load = 1'b0;
    timer_val  = SLOT_LOAD;
    case (state_reg)
      REQ: begin
        timer_load = bus.q_ack;
        timer_val  = SLOT_LOAD;
      end
      ASK: begin
        timer_load = bus.key_valid || timer_zero;
        timer_val  = SHOW_LOAD;
      end
      default: ;
    endcase
  end

  assign timer_en   = (state_reg == ASK) || (state_reg == SHOW);
  assign round_next = (round_reg == ROUND_LAST) ? round_reg : round_reg + 1'b1;

  slot_timer #(.TMR_W(TMR_W)) u_timer (
    .clk_fast  (clk_fast),
    .restart_n (restart_n),
    .load      (timer_load),
    .load_val  (timer_val),
    .en        (timer_en),
    .zero      (timer_zero)
  );

  always_ff @(posedge clk_fast or negedge restart_n) begin
    if (!restart_n) begin
      state_reg     <= IDLE;
      score_reg     <= '0;
      round_reg     <= '0;
      feedback_reg  <= FB_NONE;
      q_req_reg     <= 1'b0;
      game_over_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, OVER: begin
          if (bus.start) begin
            state_reg     <= REQ;
            score_reg     <= '0;
            round_reg     <= '0;
            feedback_reg  <= FB_NONE;
            q_req_reg     <= 1'b1;
            game_over_reg <= 1'b0;
          end
        end
        REQ: begin
          if (bus.q_ack) begin
            state_reg <= ASK;
            q_req_reg <= 1'b0;
          end
        end
        ASK: begin
          // A key arriving on the last slot cycle still counts as an answer
          if (bus.key_valid) begin
            score_reg    <= score_step(score_reg, bus.answer, SCORE_TOP);
            feedback_reg <= bus.answer ? FB_OK : FB_BAD;
            state_reg    <= SHOW;
          end else if (timer_zero) begin
            feedback_reg <= FB_TMO;
`ifdef TIMEOUT_PENALTY_EN
            score_reg    <= score_step(score_reg, 1'b0, SCORE_TOP);
`else
            score_reg    <= score_reg;
`endif
            state_reg    <= SHOW;
          end
        end
        SHOW: begin
          if (timer_zero) begin
            round_reg <= round_next;
            if ((score_reg == SCORE_TOP) || (round_next == ROUND_LAST)) begin
              state_reg     <= OVER;
              game_over_reg <= 1'b1;
            end else begin
              state_reg    <= REQ;
              q_req_reg    <= 1'b1;
              feedback_reg <= FB_NONE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.q_req     = q_req_reg;
  assign bus.score     = score_reg;
  assign bus.round     = round_reg;
  assign bus.feedback  = feedback_reg;
  assign bus.game_over = game_over_reg;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: directed round table, corner
// sequences (async reset, max score, max rounds) and randomized whole games.
module tb_round_sequencer;
  import game_pkg::*;

  localparam int SLOT = 20;
  localparam int SHOW = 4;
  localparam int MAXS = 9;
  localparam int MAXR = 15;
`ifdef TIMEOUT_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk_fast  = 1'b0;
  logic restart_n = 1'b0;
  always #5 clk_fast = ~clk_fast;

  round_sequencer_if bus();

  round_sequencer #(
    .SLOT_CYCLES (SLOT),
    .SHOW_CYCLES (SHOW),
    .MAX_SCORE   (MAXS),
    .MAX_ROUNDS  (MAXR),
    .TMR_W       (30)
  ) dut (
    .clk_fast  (clk_fast),
    .restart_n (restart_n),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int key_at;     // ASK cycle of the press; SLOT means no press (timeout)
    bit ans;
    bit extra;      // follow-up press landing in SHOW
    int exp_score;
    int exp_fb;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(negedge clk_fast);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference scoring rule, applied once per round
  function automatic int model_score(input int s, input int key_at, input bit ans);
    if (key_at >= SLOT) return PEN ? ((s > 0) ? s - 1 : 0) : s;
    if (ans) return (s < MAXS) ? s + 1 : MAXS;
    return (s > 0) ? s - 1 : 0;
  endfunction

  function automatic int model_fb(input int key_at, input bit ans);
    if (key_at >= SLOT) return 3;
    return ans ? 1 : 2;
  endfunction

  task automatic start_game();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_score", bus.score, 0);
    check("start_round", bus.round, 0);
    check("start_qreq", bus.q_req, 1);
    check("start_over", bus.game_over, 0);
  endtask

  task automatic run_round(input int key_at, input bit ans, input bit extra,
                           input int prev_score, input int exp_score, input int exp_fb,
                           input int exp_round, input bit exp_over);
    check("qreq_before_ack", bus.q_req, 1);
    bus.q_ack = 1'b1;
    step();
    bus.q_ack = 1'b0;
    check("qreq_after_ack", bus.q_req, 0);
    check("fb_in_ask", bus.feedback, 0);
    if (key_at >= SLOT) begin
      repeat (SLOT - 1) step();
      check("score_pre_timeout", bus.score, prev_score);
      check("fb_pre_timeout", bus.feedback, 0);
      step();
    end else begin
      repeat (key_at) step();
      check("score_pre_key", bus.score, prev_score);
      bus.key_valid = 1'b1;
      bus.answer    = ans;
      step();
      bus.key_valid = 1'b0;
    end
    check("score_after", bus.score, exp_score);
    check("fb_after", bus.feedback, exp_fb);
    if (extra) begin
      bus.key_valid = 1'b1;
      bus.answer    = (exp_score < MAXS);
      step();
      bus.key_valid = 1'b0;
      check("lockout_score", bus.score, exp_score);
    end
    repeat (SHOW - 1 - int'(extra)) step();
    check("round_hold", bus.round, exp_round - 1);
    step();
    check("round_done", bus.round, exp_round);
    check("over_flag", bus.game_over, exp_over);
    check("qreq_next", bus.q_req, !exp_over);
    check("score_end", bus.score, exp_score);
    $display("[TB] round %0d key_at=%0d ans=%0d extra=%0d score=%0d fb=%0d over=%0d",
             exp_round, key_at, ans, extra, bus.score, bus.feedback, bus.game_over);
  endtask

  initial begin
    int s;
    int r;
    int k;
    bit a;
    bit x;
    int ns;

    vecs[0] = '{5,     1'b1, 1'b0, 1,           1};
    vecs[1] = '{3,     1'b0, 1'b0, 0,           2};
    vecs[2] = '{0,     1'b0, 1'b0, 0,           2};
    vecs[3] = '{7,     1'b1, 1'b0, 1,           1};
    vecs[4] = '{12,    1'b1, 1'b0, 2,           1};
    vecs[5] = '{1,     1'b1, 1'b0, 3,           1};
    vecs[6] = '{9,     1'b0, 1'b0, 2,           2};
    vecs[7] = '{SLOT,  1'b0, 1'b0, PEN ? 1 : 2, 3};
    vecs[8] = '{SLOT-1, 1'b1, 1'b0, PEN ? 2 : 3, 1};
    vecs[9] = '{2,     1'b1, 1'b1, PEN ? 3 : 4, 1};

    bus.start = 1'b0; bus.key_valid = 1'b0; bus.answer = 1'b0; bus.q_ack = 1'b0;
    repeat (3) step();
    check("rst_score", bus.score, 0);
    check("rst_round", bus.round, 0);
    check("rst_qreq", bus.q_req, 0);
    check("rst_fb", bus.feedback, 0);
    check("rst_over", bus.game_over, 0);
    restart_n = 1'b1;
    bus.q_ack = 1'b1;
    step();
    bus.q_ack = 1'b0;
    check("idle_ignores_ack", bus.q_req, 0);
    start_game();

    // Directed round table
    s = 0;
    for (int i = 0; i < 10; i++) begin
      run_round(vecs[i].key_at, vecs[i].ans, vecs[i].extra, s,
                vecs[i].exp_score, vecs[i].exp_fb, i + 1, 1'b0);
      s = vecs[i].exp_score;
    end

    // Asynchronous reset in the middle of an answer slot
    bus.q_ack = 1'b1;
    step();
    bus.q_ack = 1'b0;
    repeat (3) step();
    #2 restart_n = 1'b0;
    #1;
    check("async_score", bus.score, 0);
    check("async_round", bus.round, 0);
    check("async_qreq", bus.q_req, 0);
    check("async_fb", bus.feedback, 0);
    check("async_over", bus.game_over, 0);
    step();
    restart_n = 1'b1;
    step();
    check("idle_after_rst", bus.q_req, 0);
    start_game();

    // Nine correct answers end the game on maximum score
    for (int i = 0; i < MAXS; i++) begin
      run_round($urandom_range(0, SLOT - 1), 1'b1, 1'b0, i, i + 1, 1, i + 1, i == MAXS - 1);
    end
    bus.key_valid = 1'b1; bus.answer = 1'b0; bus.q_ack = 1'b1;
    step();
    bus.key_valid = 1'b0; bus.q_ack = 1'b0;
    step();
    check("over_score_frozen", bus.score, MAXS);
    check("over_round_frozen", bus.round, MAXS);
    check("over_held", bus.game_over, 1);
    check("over_no_qreq", bus.q_req, 0);
    start_game();

    // Fifteen timeouts end the game on maximum rounds
    for (int i = 0; i < MAXR; i++) begin
      run_round(SLOT, 1'b0, 1'b0, 0, 0, 3, i + 1, i == MAXR - 1);
    end
    repeat (2) step();
    check("maxr_round_hold", bus.round, MAXR);
    check("maxr_over_hold", bus.game_over, 1);

    // Randomized whole games against the per-round model
    for (int g = 0; g < 4; g++) begin
      start_game();
      s = 0;
      r = 0;
      while (1) begin
        k  = ($urandom_range(0, 5) == 0) ? SLOT : int'($urandom_range(0, SLOT - 1));
        a  = ($urandom_range(0, 9) < 7);
        x  = $urandom_range(0, 1);
        ns = model_score(s, k, a);
        r++;
        run_round(k, a, x, s, ns, model_fb(k, a), r, (ns == MAXS) || (r == MAXR));
        s = ns;
        if ((s == MAXS) || (r == MAXR)) break;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
